// File: rtl/cpu_run_checker_if.sv
// Observation and control bundle between a CPU bench and cpu_run_checker.
// The bench (master) drives CPU state and the check table, and the checker (slave) returns the run verdict.
interface cpu_run_checker_if #(
    parameter int NUM_CHECKS = 4,
    parameter int CNT_W      = 32
);
    localparam int FC_W = $clog2(NUM_CHECKS + 1);
    localparam int FI_W = $clog2(NUM_CHECKS) | 1;

    logic              start;
    logic [31:0]       pc_debug;
    logic [31:0]       regs_debug [0:31];
    logic              halt_pc_en;
    logic [31:0]       halt_pc;
    logic [4:0]        chk_reg [NUM_CHECKS];
    logic [31:0]       chk_val [NUM_CHECKS];

    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [FC_W-1:0]   fail_count;
    logic [FI_W-1:0]   first_fail_idx;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output start, pc_debug, regs_debug, halt_pc_en, halt_pc, chk_reg, chk_val,
        input  busy, done, pass, timeout, fail_count, first_fail_idx, cycle_count
    );

    modport slave (
        input  start, pc_debug, regs_debug, halt_pc_en, halt_pc, chk_reg, chk_val,
        output busy, done, pass, timeout, fail_count, first_fail_idx, cycle_count
    );
endinterface

// File: rtl/cpu_run_checker.sv
// Run-control and result checker for CPU benches: detects halt by PC match or a stable PC,
// guards the run with a timeout, then walks a table of expected register values.
module cpu_run_checker #(
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STABLE_CYCLES  = 16,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    cpu_run_checker_if.slave   bus
);
    localparam int FC_W = $clog2(NUM_CHECKS + 1);
    localparam int FI_W = $clog2(NUM_CHECKS) | 1;
    localparam int IW   = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int SW   = $clog2(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cycle_count, cycle_nxt;
    logic [SW-1:0]     stable_cnt, stable_nxt;
    logic [31:0]       last_pc, last_pc_nxt;
    logic [IW-1:0]     chk_idx, chk_idx_nxt;
    logic [FC_W-1:0]   fail_count, fail_nxt;
    logic [FI_W-1:0]   first_fail_idx, ffi_nxt;
    logic              timeout_q, timeout_nxt;
    logic              pass_q, pass_nxt;

    logic [CNT_W-1:0]  cnt_inc;
    logic [SW-1:0]     stable_inc;
    logic [FC_W-1:0]   fail_inc;
    logic              pc_same;
    logic              halt_hit;
    logic              entry_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cycle_count    <= '0;
            stable_cnt     <= '0;
            last_pc        <= '0;
            chk_idx        <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timeout_q      <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state          <= state_nxt;
            cycle_count    <= cycle_nxt;
            stable_cnt     <= stable_nxt;
            last_pc        <= last_pc_nxt;
            chk_idx        <= chk_idx_nxt;
            fail_count     <= fail_nxt;
            first_fail_idx <= ffi_nxt;
            timeout_q      <= timeout_nxt;
            pass_q         <= pass_nxt;
        end
    end

    // A start pulse restarts from any state, so an abandoned run never leaves a partial report.
    always_comb begin
        state_nxt   = state;
        cycle_nxt   = cycle_count;
        stable_nxt  = stable_cnt;
        last_pc_nxt = last_pc;
        chk_idx_nxt = chk_idx;
        fail_nxt    = fail_count;
        ffi_nxt     = first_fail_idx;
        timeout_nxt = timeout_q;
        pass_nxt    = pass_q;

        cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
        stable_inc = stable_cnt + 1'b1;
        fail_inc   = fail_count + 1'b1;
        pc_same    = (bus.pc_debug == last_pc);
        halt_hit   = (bus.halt_pc_en && (bus.pc_debug == bus.halt_pc))
                   || (pc_same && (stable_inc == SW'(STABLE_CYCLES - 1)));
        entry_bad  = (bus.regs_debug[bus.chk_reg[chk_idx]] != bus.chk_val[chk_idx]);

        if (bus.start) begin
            state_nxt   = RUN;
            cycle_nxt   = '0;
            stable_nxt  = '0;
            last_pc_nxt = bus.pc_debug;
            chk_idx_nxt = '0;
            fail_nxt    = '0;
            ffi_nxt     = '0;
            timeout_nxt = 1'b0;
            pass_nxt    = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    cycle_nxt = cnt_inc;
                    if (pc_same) begin
                        stable_nxt = stable_inc;
                    end else begin
                        stable_nxt  = '0;
                        last_pc_nxt = bus.pc_debug;
                    end
                    // Halt is tested first so a halt on the last allowed cycle is still checked.
                    if (halt_hit) begin
                        state_nxt   = CHECK;
                        chk_idx_nxt = '0;
                    end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt   = DONE;
                        timeout_nxt = 1'b1;
                        pass_nxt    = 1'b0;
                    end
                end
                CHECK: begin
                    if (entry_bad) begin
                        fail_nxt = fail_inc;
                        if (fail_count == '0) begin
                            ffi_nxt = FI_W'(chk_idx);
                        end
                    end
                    if (chk_idx == IW'(NUM_CHECKS - 1)) begin
                        state_nxt = DONE;
                        pass_nxt  = entry_bad ? 1'b0 : (fail_count == '0);
                    end else begin
                        chk_idx_nxt = chk_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy           = (state == RUN) || (state == CHECK);
    assign bus.done           = (state == DONE);
    assign bus.pass           = pass_q;
    assign bus.timeout        = timeout_q;
    assign bus.fail_count     = fail_count;
    assign bus.first_fail_idx = first_fail_idx;
    assign bus.cycle_count    = cycle_count;
endmodule

// File: tb/tb_cpu_run_checker.sv
// Directed bench for cpu_run_checker: a modelled PC walks toward a self-loop or halt address
// while a small register file supplies the values the check table expects.
module tb_cpu_run_checker;
    localparam int NUM_CHECKS     = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int STABLE_CYCLES  = 4;
    localparam int CNT_W          = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_run;
    logic [31:0] pc_limit;
    int          checks = 0;
    int          errors = 0;

    cpu_run_checker_if #(.NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)) bus ();

    cpu_run_checker #(
        .NUM_CHECKS(NUM_CHECKS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of the modelled CPU: the PC advances by 4 until it parks at pc_limit.
    task automatic stepCycle();
        @(negedge clk);
        if (pc_run && (bus.pc_debug < pc_limit)) bus.pc_debug = bus.pc_debug + 32'd4;
    endtask

    task automatic applyStimulus(input logic [31:0] start_pc);
        @(negedge clk);
        bus.pc_debug = start_pc;
        bus.start    = 1'b1;
        stepCycle();
        bus.start    = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.done && (n < budget)) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic exp_pass, input logic exp_to,
                               input int exp_fail, input int exp_ffi, input int exp_cyc);
        checkOutput({tag, ".pass"},    32'(bus.pass),           32'(exp_pass));
        checkOutput({tag, ".timeout"}, 32'(bus.timeout),        32'(exp_to));
        checkOutput({tag, ".fails"},   32'(bus.fail_count),     32'(exp_fail));
        checkOutput({tag, ".ffi"},     32'(bus.first_fail_idx), 32'(exp_ffi));
        checkOutput({tag, ".cycles"},  32'(bus.cycle_count),    32'(exp_cyc));
        checkOutput({tag, ".busy"},    32'(bus.busy),           32'd0);
    endtask

    task automatic setTable(input logic [31:0] val1, input logic [31:0] val3);
        bus.chk_reg[0] = 5'd6;   bus.chk_val[0] = 32'h0000_0000;
        bus.chk_reg[1] = 5'd1;   bus.chk_val[1] = val1;
        bus.chk_reg[2] = 5'd0;   bus.chk_val[2] = 32'h0000_0055;
        bus.chk_reg[3] = 5'd31;  bus.chk_val[3] = val3;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=stuck expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        pc_run         = 1'b0;
        pc_limit       = 32'h0;
        bus.start      = 1'b0;
        bus.pc_debug   = 32'h0;
        bus.halt_pc_en = 1'b0;
        bus.halt_pc    = 32'h0;
        for (int i = 0; i < 32; i++) bus.regs_debug[i] = 32'h1000 + 32'(i);
        bus.regs_debug[0]  = 32'h0000_0055;
        bus.regs_debug[1]  = 32'h1234_0000;
        bus.regs_debug[6]  = 32'h0000_0000;
        bus.regs_debug[31] = 32'hCAFE_F00D;
        setTable(32'h1234_0000, 32'hCAFE_F00D);

        #12;
        checkOutput("rst.busy",   32'(bus.busy),        32'd0);
        checkOutput("rst.done",   32'(bus.done),        32'd0);
        checkOutput("rst.pass",   32'(bus.pass),        32'd0);
        checkOutput("rst.cycles", 32'(bus.cycle_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("idle.busy", 32'(bus.busy), 32'd0);
        checkOutput("idle.done", 32'(bus.done), 32'd0);

        // Self-loop program: PC climbs to 0x14 and parks; index 0 is checked like any register.
        pc_run   = 1'b1;
        pc_limit = 32'h14;
        applyStimulus(32'h0);
        checkOutput("t1.busy_run", 32'(bus.busy), 32'd1);
        checkOutput("t1.done_run", 32'(bus.done), 32'd0);
        waitDone("t1.done", 200);
        checkResult("t1", 1'b1, 1'b0, 0, 0, 8);
        repeat (3) stepCycle();
        checkOutput("t1.hold_done", 32'(bus.done), 32'd1);
        checkOutput("t1.hold_pass", 32'(bus.pass), 32'd1);

        setTable(32'h1234_0001, 32'hCAFE_F00D);
        applyStimulus(32'h0);
        waitDone("t2.done", 200);
        checkResult("t2", 1'b0, 1'b0, 1, 1, 8);

        setTable(32'h1234_0001, 32'hCAFE_F00E);
        applyStimulus(32'h0);
        waitDone("t2b.done", 200);
        checkResult("t2b", 1'b0, 1'b0, 2, 1, 8);

        setTable(32'h1234_0000, 32'hCAFE_F00E);
        applyStimulus(32'h0);
        waitDone("t2c.done", 200);
        checkResult("t2c", 1'b0, 1'b0, 1, 3, 8);

        // Runaway PC with halt matching disabled ends on the timeout.
        setTable(32'h1234_0000, 32'hCAFE_F00D);
        pc_limit       = 32'hFFFF_FFF0;
        bus.halt_pc    = 32'h20;
        bus.halt_pc_en = 1'b0;
        applyStimulus(32'h0);
        waitDone("t3.done", 200);
        checkResult("t3", 1'b0, 1'b1, 0, 0, 49);

        bus.halt_pc_en = 1'b1;
        pc_limit       = 32'h40;
        applyStimulus(32'h0);
        repeat (7) stepCycle();
        checkOutput("t4.pre_busy", 32'(bus.busy), 32'd1);
        stepCycle();
        checkOutput("t4.in_check", 32'(bus.busy), 32'd1);
        checkOutput("t4.cyc_halt", 32'(bus.cycle_count), 32'd8);
        repeat (3) stepCycle();
        checkOutput("t4.not_yet", 32'(bus.done), 32'd0);
        checkOutput("t4.cyc_frozen", 32'(bus.cycle_count), 32'd8);
        stepCycle();
        checkOutput("t4.done_at5", 32'(bus.done), 32'd1);
        checkResult("t4", 1'b1, 1'b0, 0, 0, 8);

        // Halt address reached on exactly the cycle the timeout would fire.
        bus.halt_pc = 32'hC4;
        pc_limit    = 32'hFFFF_FFF0;
        applyStimulus(32'h0);
        waitDone("t5.done", 200);
        checkResult("t5", 1'b1, 1'b0, 0, 0, 49);

        setTable(32'h1234_0001, 32'hCAFE_F00D);
        bus.halt_pc = 32'h20;
        pc_limit    = 32'h40;
        applyStimulus(32'h0);
        repeat (10) stepCycle();
        checkOutput("t6.mid_fail", 32'(bus.fail_count), 32'd1);
        applyStimulus(32'h0);
        checkOutput("t6.cleared", 32'(bus.fail_count), 32'd0);
        checkOutput("t6.restart_busy", 32'(bus.busy), 32'd1);
        checkOutput("t6.restart_cyc", 32'(bus.cycle_count), 32'd0);
        waitDone("t6.done", 200);
        checkResult("t6", 1'b0, 1'b0, 1, 1, 8);

        setTable(32'h1234_0000, 32'hCAFE_F00D);
        bus.halt_pc_en = 1'b0;
        pc_limit       = 32'hFFFF_FFF0;
        applyStimulus(32'h0);
        repeat (20) stepCycle();
        applyStimulus(32'h0);
        checkOutput("t7.restart_cyc", 32'(bus.cycle_count), 32'd0);
        waitDone("t7.done", 200);
        checkResult("t7", 1'b0, 1'b1, 0, 0, 49);

        // Asynchronous reset while the table walk is in progress.
        bus.halt_pc_en = 1'b1;
        pc_limit       = 32'h40;
        applyStimulus(32'h0);
        repeat (9) stepCycle();
        checkOutput("t8.in_check", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t8.rst_busy",   32'(bus.busy),        32'd0);
        checkOutput("t8.rst_done",   32'(bus.done),        32'd0);
        checkOutput("t8.rst_cycles", 32'(bus.cycle_count), 32'd0);
        checkOutput("t8.rst_fails",  32'(bus.fail_count),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) stepCycle();
        checkOutput("t8.no_done", 32'(bus.done), 32'd0);
        bus.halt_pc_en = 1'b0;
        pc_limit       = 32'h14;
        applyStimulus(32'h0);
        waitDone("t8.done", 200);
        checkResult("t8", 1'b1, 1'b0, 0, 0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
